ntt_cmd_seq: RTL and testbench

Command sequencer that drives the NTT core's `conf` bus and consumes its `done_flag`. It is the initiator for the index/control FSM. It accepts single-operation or chained polynomial-multiply commands from the host side and steps `conf` through run and pipeline-drain codes. It enforces a drain interval so the core's delayed write enables retire before the next operation, and returns one response per command with a cycle count and a timeout error.

---
 rtl/ntt_cmd_seq.sv | 134 +++++++++++++
 tb/tb_ntt_cmd_seq.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_cmd_seq.sv
// ntt_cmd_seq: command sequencer for the NTT core.
// Steps the core's conf bus through run and drain codes for single operations
// or the NTT -> PWM -> INTT multiply chain. Every run code is followed by a
// fixed drain interval so the core's delayed write enables retire. One
// response is returned per command, carrying the RUN cycle count and a
// watchdog timeout flag.
module ntt_cmd_seq #(
  parameter int DRAIN_CYCLES = 9,
  parameter int TIMEOUT      = 4096
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_cmd_valid,
  input  logic [1:0]  i_cmd_op,
  output logic        o_cmd_ready,
  input  logic [3:0]  i_done_flag,
  output logic [2:0]  o_conf,
  output logic        o_busy,
  output logic        o_rsp_valid,
  output logic [1:0]  o_rsp_op,
  output logic        o_rsp_err,
  output logic [15:0] o_run_cycles
);

  localparam logic [2:0]  CONF_IDLE      = 3'd0;
  localparam logic [2:0]  CONF_DONE_NTT  = 3'd4;
  localparam logic [2:0]  CONF_DONE_INTT = 3'd5;
  localparam logic [1:0]  OP_MUL         = 2'd3;
  localparam logic [1:0]  STEP_INTT      = 2'd2;
  localparam logic [15:0] WD_LAST        = 16'(TIMEOUT - 1);
  localparam logic [7:0]  DRAIN_LOAD     = 8'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t      r_state;
  logic [1:0]  r_step;
  logic [1:0]  r_opQ;
  logic [15:0] r_wd;
  logic [7:0]  r_drainCnt;
  logic [15:0] r_runCycles;
  logic        r_errQ;
  logic [2:0]  r_conf;
  logic        r_rspValid;

  logic        w_stepDone;
  logic        w_timeout;
  logic [15:0] w_runInc;
  logic [1:0]  w_startStep;
  logic [2:0]  w_drainCode;
  logic        w_chainNext;

  // Only the done bit belonging to the current step is decoded.
  assign w_stepDone  = i_done_flag[r_step];
  assign w_timeout   = (r_wd == WD_LAST);
  assign w_runInc    = (r_runCycles == 16'hFFFF) ? r_runCycles : r_runCycles + 16'd1;
  assign w_startStep = (i_cmd_op == OP_MUL) ? 2'd0 : i_cmd_op;
  assign w_drainCode = (r_step == STEP_INTT) ? CONF_DONE_INTT : CONF_DONE_NTT;
  assign w_chainNext = (r_opQ == OP_MUL) && !r_errQ && (r_step != STEP_INTT);

  // Sequencer FSM: accept, run with watchdog, drain, then chain or respond.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_step      <= 2'd0;
      r_opQ       <= 2'd0;
      r_wd        <= 16'd0;
      r_drainCnt  <= 8'd0;
      r_runCycles <= 16'd0;
      r_errQ      <= 1'b0;
      r_conf      <= CONF_IDLE;
      r_rspValid  <= 1'b0;
    end else begin
      r_rspValid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_cmd_valid) begin
            r_opQ       <= i_cmd_op;
            r_runCycles <= 16'd0;
            r_errQ      <= 1'b0;
            r_step      <= w_startStep;
            r_wd        <= 16'd0;
            r_conf      <= {1'b0, w_startStep} + 3'd1;
            r_state     <= S_RUN;
          end
        end
        S_RUN: begin
          r_wd        <= r_wd + 16'd1;
          r_runCycles <= w_runInc;
          if (w_stepDone || w_timeout) begin
            if (!w_stepDone) begin
              r_errQ <= 1'b1;
            end
            r_conf     <= w_drainCode;
            r_drainCnt <= DRAIN_LOAD;
            r_state    <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (r_drainCnt == 8'd0) begin
            if (w_chainNext) begin
              r_step  <= r_step + 2'd1;
              r_conf  <= {1'b0, r_step} + 3'd2;
              r_wd    <= 16'd0;
              r_state <= S_RUN;
            end else begin
              r_conf     <= CONF_IDLE;
              r_rspValid <= 1'b1;
              r_state    <= S_IDLE;
            end
          end else begin
            r_drainCnt <= r_drainCnt - 8'd1;
          end
        end
        default: begin
          r_conf  <= CONF_IDLE;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_cmd_ready  = (r_state == S_IDLE);
  assign o_busy       = (r_state != S_IDLE);
  assign o_conf       = r_conf;
  assign o_rsp_valid  = r_rspValid;
  assign o_rsp_op     = r_opQ;
  assign o_rsp_err    = r_errQ;
  assign o_run_cycles = r_runCycles;

endmodule

// File: tb/tb_ntt_cmd_seq.sv
// Testbench for ntt_cmd_seq: two instances (default watchdog and a short
// watchdog of 16). The expected per-cycle conf trace of each command is
// built from the command rules, then replayed cycle by cycle.
module tb_ntt_cmd_seq;

  localparam int DRAIN  = 9;
  localparam int TO_A   = 4096;
  localparam int TO_B   = 16;

  logic clk = 1'b0;
  logic rstN;
  logic selTo;
  logic cmdValid;
  logic [1:0] cmdOp;
  logic [3:0] doneFlag;

  logic aCmdValid, bCmdValid;
  logic [3:0] aDone, bDone;
  logic aReady, bReady, aBusy, bBusy, aRspValid, bRspValid, aRspErr, bRspErr;
  logic [2:0] aConf, bConf;
  logic [1:0] aRspOp, bRspOp;
  logic [15:0] aRun, bRun;

  logic obsReady, obsBusy, obsRspValid, obsRspErr;
  logic [2:0] obsConf;
  logic [1:0] obsRspOp;
  logic [15:0] obsRun;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] conf;
    logic [3:0] drive;
    bit         last;
  } entry_t;

  entry_t tbl[$];

  // Free-running clock, rising edge active.
  always #5 clk = ~clk;

  // Route the shared stimulus to whichever instance is selected; the other idles.
  assign aCmdValid = selTo ? 1'b0 : cmdValid;
  assign bCmdValid = selTo ? cmdValid : 1'b0;
  assign aDone     = selTo ? 4'd0 : doneFlag;
  assign bDone     = selTo ? doneFlag : 4'd0;

  assign obsReady    = selTo ? bReady    : aReady;
  assign obsBusy     = selTo ? bBusy     : aBusy;
  assign obsRspValid = selTo ? bRspValid : aRspValid;
  assign obsRspErr   = selTo ? bRspErr   : aRspErr;
  assign obsConf     = selTo ? bConf     : aConf;
  assign obsRspOp    = selTo ? bRspOp    : aRspOp;
  assign obsRun      = selTo ? bRun      : aRun;

  ntt_cmd_seq #(.DRAIN_CYCLES(DRAIN), .TIMEOUT(TO_A)) dutA (
    .i_clk(clk), .i_rst_n(rstN), .i_cmd_valid(aCmdValid), .i_cmd_op(cmdOp),
    .o_cmd_ready(aReady), .i_done_flag(aDone), .o_conf(aConf), .o_busy(aBusy),
    .o_rsp_valid(aRspValid), .o_rsp_op(aRspOp), .o_rsp_err(aRspErr),
    .o_run_cycles(aRun)
  );

  ntt_cmd_seq #(.DRAIN_CYCLES(DRAIN), .TIMEOUT(TO_B)) dutB (
    .i_clk(clk), .i_rst_n(rstN), .i_cmd_valid(bCmdValid), .i_cmd_op(cmdOp),
    .o_cmd_ready(bReady), .i_done_flag(bDone), .o_conf(bConf), .o_busy(bBusy),
    .o_rsp_valid(bRspValid), .o_rsp_op(bRspOp), .o_rsp_err(bRspErr),
    .o_run_cycles(bRun)
  );

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, " conf"}, 16'(obsConf), 16'd0);
    checkOutput({tag, " rsp_valid"}, 16'(obsRspValid), 16'd0);
    checkOutput({tag, " busy"}, 16'(obsBusy), 16'd0);
    checkOutput({tag, " cmd_ready"}, 16'(obsReady), 16'd1);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkIdle("idle");
      cmdValid = 1'b0;
      doneFlag = 4'($urandom);
    end
  endtask

  // Issue one command (starting at a negedge in an IDLE cycle) and compare the
  // whole conf trace plus the final response against the reference trace.
  task automatic applyStimulus(input logic [1:0] op, input int n0, input int n1, input int n2);
    int steps[$];
    int durs[$];
    int to;
    int runTotal;
    int runLen;
    int s;
    bit err;
    logic [3:0] expBit;
    logic [15:0] expRun;
    entry_t e;

    to = selTo ? TO_B : TO_A;
    runTotal = 0;
    err = 1'b0;
    tbl.delete();
    if (op == 2'd3) begin
      steps = '{0, 1, 2};
      durs  = '{n0, n1, n2};
    end else begin
      steps = '{int'(op)};
      durs  = '{n0};
    end

    foreach (steps[i]) begin
      s = steps[i];
      expBit = 4'(1) << s;
      runLen = (durs[i] <= to) ? durs[i] : to;
      for (int k = 1; k <= runLen; k++) begin
        e.conf = 3'(s + 1);
        e.last = 1'b0;
        if (k == durs[i]) e.drive = 4'($urandom) | expBit;
        else              e.drive = 4'hF & ~expBit;
        tbl.push_back(e);
      end
      runTotal += runLen;
      for (int k = 0; k < DRAIN; k++) begin
        e.conf  = (s == 2) ? 3'd5 : 3'd4;
        e.drive = 4'($urandom) | 4'b0001;
        e.last  = 1'b0;
        tbl.push_back(e);
      end
      if (durs[i] > to) begin
        err = 1'b1;
        break;
      end
    end
    e.conf  = 3'd0;
    e.drive = 4'd0;
    e.last  = 1'b1;
    tbl.push_back(e);
    expRun = (runTotal > 65535) ? 16'hFFFF : 16'(runTotal);

    cmdValid = 1'b1;
    cmdOp    = op;
    doneFlag = 4'd0;
    foreach (tbl[t]) begin
      @(negedge clk);
      checkOutput("conf", 16'(obsConf), 16'(tbl[t].conf));
      checkOutput("rsp_valid", 16'(obsRspValid), 16'(tbl[t].last));
      checkOutput("busy", 16'(obsBusy), 16'(!tbl[t].last));
      checkOutput("cmd_ready", 16'(obsReady), 16'(tbl[t].last));
      if (tbl[t].last) begin
        checkOutput("rsp_op", 16'(obsRspOp), 16'(op));
        checkOutput("rsp_err", 16'(obsRspErr), 16'(err));
        checkOutput("run_cycles", obsRun, expRun);
        cmdValid = 1'b0;
        doneFlag = 4'd0;
      end else begin
        doneFlag = tbl[t].drive;
        cmdValid = 1'($urandom_range(0, 1));
        cmdOp    = 2'($urandom);
      end
    end
  endtask

  initial begin
    logic [1:0] rop;
    int lim;

    rstN = 1'b1;
    selTo = 1'b0;
    cmdValid = 1'b0;
    cmdOp = 2'd0;
    doneFlag = 4'd0;
    #1 rstN = 1'b0;
    #2;
    checkIdle("reset");
    checkOutput("reset rsp_op", 16'(obsRspOp), 16'd0);
    checkOutput("reset rsp_err", 16'(obsRspErr), 16'd0);
    checkOutput("reset run_cycles", obsRun, 16'd0);
    @(negedge clk);
    rstN = 1'b1;
    idleCycles(2);

    // Directed: single NTT, INTT with drain noise, MUL chain back to back.
    applyStimulus(2'd0, 2560, 0, 0);
    idleCycles(1);
    applyStimulus(2'd2, 2560, 0, 0);
    applyStimulus(2'd3, 2560, 256, 2560);
    idleCycles(1);
    // PWM with wrong done bits held high until the real one arrives.
    applyStimulus(2'd1, 40, 0, 0);
    idleCycles(1);

    // Short watchdog: timeout, chain abort, done exactly on the last cycle.
    selTo = 1'b1;
    applyStimulus(2'd0, 100, 0, 0);
    applyStimulus(2'd3, 100, 5, 5);
    idleCycles(1);
    applyStimulus(2'd3, 16, 16, 16);
    applyStimulus(2'd3, 3, 17, 4);
    idleCycles(1);

    // Randomized commands across both instances.
    for (int i = 0; i < 24; i++) begin
      selTo = 1'($urandom_range(0, 1));
      rop = 2'($urandom);
      lim = selTo ? 22 : 60;
      applyStimulus(rop, $urandom_range(1, lim), $urandom_range(1, lim), $urandom_range(1, lim));
      if ($urandom_range(0, 1) == 1) idleCycles($urandom_range(1, 3));
    end

    // Reset in the middle of a RUN, then a fresh PWM on the first edge.
    selTo = 1'b0;
    idleCycles(1);
    cmdValid = 1'b1;
    cmdOp = 2'd0;
    doneFlag = 4'd0;
    @(negedge clk);
    cmdValid = 1'b0;
    checkOutput("midrst run conf", 16'(obsConf), 16'd1);
    repeat (5) @(negedge clk);
    #2 rstN = 1'b0;
    #1;
    checkIdle("midrst");
    checkOutput("midrst run_cycles", obsRun, 16'd0);
    checkOutput("midrst rsp_op", 16'(obsRspOp), 16'd0);
    @(negedge clk);
    checkIdle("midrst hold");
    rstN = 1'b1;
    applyStimulus(2'd1, 30, 0, 0);
    idleCycles(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
